// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential shift-and-add multiplier with start/done handshake.
// Define MULT_SIGNED_EN for two's-complement operands and product.
module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] a, q, m;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   sum;
  // sum is {C,A} after the add step; its MSB is the carry (or sign) shifted into A
`ifdef MULT_SIGNED_EN
  always_comb sum = !q[0] ? {a[WIDTH-1], a} :
                    count == CW'(1) ? {a[WIDTH-1], a} - {m[WIDTH-1], m} :
                                      {a[WIDTH-1], a} + {m[WIDTH-1], m};
`else
  always_comb sum = q[0] ? {1'b0, a} + {1'b0, m} : {1'b0, a};
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      a       <= '0;
      q       <= '0;
      m       <= '0;
      count   <= '0;
      product <= '0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= CALC;
          a     <= '0;
          q     <= multiplier;
          m     <= multiplicand;
          count <= CW'(WIDTH);
          ready <= 1'b0;
          busy  <= 1'b1;
        end
        CALC: begin
          a     <= sum[WIDTH:1];
          q     <= {sum[0], q[WIDTH-1:1]};
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            state   <= DONE;
            product <= {sum, q[WIDTH-1:1]};
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
